mem_access_ctrl: RTL and testbench

- Sequences MEM-stage data-memory accesses between the EX/MEM pipeline register outputs and a multi-cycle req/gnt/rvalid data bus.
- Asserts `stall_o` to freeze the front end and EX/MEM while an access is outstanding.
- Performs byte-lane steering, store strobes, load sign/zero extension, misalignment detection and a bus timeout.
- Sits beside the hazard unit; its `stall_o` is ORed into the pipeline-register enables.

---
 rtl/mem_access_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access sequencer. Drives a req/gnt/rvalid bus, stalls the pipeline
// while an access is outstanding, and handles lane steering, extension and bus timeout.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [1:0]  WD_SEL_DRAM    = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid_mem_i,
  input  logic        dram_we_mem_i,
  input  logic [1:0]  wd_sel_mem_i,
  input  logic [3:0]  sl_type_mem_i,
  input  logic [31:0] alu_result_mem_i,
  input  logic [31:0] rD2_mem_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic        mem_done_o,
  output logic [31:0] load_data_o,
  output logic        misalign_o,
  output logic        timeout_o
);

  localparam logic [3:0] SlLb  = 4'd1;
  localparam logic [3:0] SlLh  = 4'd2;
  localparam logic [3:0] SlLw  = 4'd3;
  localparam logic [3:0] SlLbu = 4'd4;
  localparam logic [3:0] SlLhu = 4'd5;
  localparam logic [3:0] SlSb  = 4'd6;
  localparam logic [3:0] SlSh  = 4'd7;
  localparam logic [3:0] SlSw  = 4'd8;

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            req_q, we_q, done_q, timeout_q;
  logic [31:0]     addr_q, wdata_q, load_data_q;
  logic [3:0]      wstrb_q, sl_q;
  logic [1:0]      off_q;

  logic        access, misalign, half_acc, word_acc;
  logic        fin_load, fin_timeout;
  logic [31:0] wdata_n, load_ext;
  logic [3:0]  wstrb_n;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign access   = instr_valid_mem_i & (dram_we_mem_i | (wd_sel_mem_i == WD_SEL_DRAM)) &
                    (sl_type_mem_i != 4'd0);
  assign half_acc = (sl_type_mem_i == SlLh) | (sl_type_mem_i == SlLhu) | (sl_type_mem_i == SlSh);
  assign word_acc = (sl_type_mem_i == SlLw) | (sl_type_mem_i == SlSw);
  assign misalign = access & ((half_acc & alu_result_mem_i[0]) |
                              (word_acc & (alu_result_mem_i[1:0] != 2'b00)));

  // Store lanes are replicated so the bus only needs the strobes to pick the byte(s).
  always_comb begin
    wdata_n = '0;
    wstrb_n = '0;
    case (sl_type_mem_i)
      SlSb: begin
        wdata_n = {4{rD2_mem_i[7:0]}};
        wstrb_n = 4'b0001 << alu_result_mem_i[1:0];
      end
      SlSh: begin
        wdata_n = {2{rD2_mem_i[15:0]}};
        wstrb_n = alu_result_mem_i[1] ? 4'b1100 : 4'b0011;
      end
      SlSw: begin
        wdata_n = rD2_mem_i;
        wstrb_n = 4'b1111;
      end
      default: ;
    endcase
  end

  assign byte_sel = mem_rdata_i[{off_q, 3'b000} +: 8];
  assign half_sel = mem_rdata_i[{off_q[1], 4'b0000} +: 16];

  always_comb begin
    load_ext = '0;
    case (sl_q)
      SlLb:    load_ext = {{24{byte_sel[7]}}, byte_sel};
      SlLh:    load_ext = {{16{half_sel[15]}}, half_sel};
      SlLw:    load_ext = mem_rdata_i;
      SlLbu:   load_ext = {24'd0, byte_sel};
      SlLhu:   load_ext = {16'd0, half_sel};
      default: load_ext = '0;
    endcase
  end

  // Completion is checked before the timeout so a last-cycle response still wins.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_o     = 1'b0;
    fin_load    = 1'b0;
    fin_timeout = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (access && !misalign) begin
          stall_o = 1'b1;
          state_d = StReq;
          cnt_d   = '0;
        end
      end
      StReq: begin
        stall_o = 1'b1;
        cnt_d   = cnt_q + CntW'(1);
        if (mem_gnt_i && we_q) begin
          state_d = StDone;
        end else if (mem_gnt_i && mem_rvalid_i) begin
          state_d  = StDone;
          fin_load = 1'b1;
        end else if (cnt_q == CntLast) begin
          state_d     = StDone;
          fin_timeout = 1'b1;
        end else if (mem_gnt_i) begin
          state_d = StWait;
        end
      end
      StWait: begin
        stall_o = 1'b1;
        cnt_d   = cnt_q + CntW'(1);
        if (mem_rvalid_i) begin
          state_d  = StDone;
          fin_load = 1'b1;
        end else if (cnt_q == CntLast) begin
          state_d     = StDone;
          fin_timeout = 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      load_data_q <= '0;
      sl_q        <= '0;
      off_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= (state_d == StReq);
      done_q      <= (state_d == StDone);
      timeout_q   <= fin_timeout;
      load_data_q <= fin_load ? load_ext : 32'd0;
      if (state_q == StIdle && state_d == StReq) begin
        addr_q  <= {alu_result_mem_i[31:2], 2'b00};
        wdata_q <= wdata_n;
        wstrb_q <= wstrb_n;
        we_q    <= dram_we_mem_i;
        sl_q    <= sl_type_mem_i;
        off_q   <= alu_result_mem_i[1:0];
      end
    end
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_wstrb_o = wstrb_q;
  assign mem_done_o  = done_q;
  assign load_data_o = load_data_q;
  assign timeout_o   = timeout_q;
  assign misalign_o  = misalign;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: table of accesses with scripted gnt/rvalid timing, a result
// scoreboard, and hand-written reset and idle-response sequences.
module tb_mem_access_ctrl;

  localparam int unsigned TO = 4;
  localparam int NEVER = 99;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid, dram_we, mem_gnt, mem_rvalid;
  logic [1:0]  wd_sel;
  logic [3:0]  sl_type;
  logic [31:0] alu_result, rd2, mem_rdata;
  logic        mem_req, mem_we, stall, mem_done, misalign, timeout;
  logic [31:0] mem_addr, mem_wdata, load_data;
  logic [3:0]  mem_wstrb;

  mem_access_ctrl #(.TIMEOUT_CYCLES(TO), .WD_SEL_DRAM(2'b01)) dut (
    .clk               (clk),
    .rst               (rst),
    .instr_valid_mem_i (instr_valid),
    .dram_we_mem_i     (dram_we),
    .wd_sel_mem_i      (wd_sel),
    .sl_type_mem_i     (sl_type),
    .alu_result_mem_i  (alu_result),
    .rD2_mem_i         (rd2),
    .mem_req_o         (mem_req),
    .mem_we_o          (mem_we),
    .mem_addr_o        (mem_addr),
    .mem_wdata_o       (mem_wdata),
    .mem_wstrb_o       (mem_wstrb),
    .mem_gnt_i         (mem_gnt),
    .mem_rvalid_i      (mem_rvalid),
    .mem_rdata_i       (mem_rdata),
    .stall_o           (stall),
    .mem_done_o        (mem_done),
    .load_data_o       (load_data),
    .misalign_o        (misalign),
    .timeout_o         (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        we;
    logic [1:0]  wd_sel;
    logic [3:0]  sl;
    logic [31:0] addr;
    logic [31:0] rd2;
    logic [31:0] rdata;
    int          gnt_at;
    int          rv_at;
    logic        exp_access;
    logic        exp_mis;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_data;
    logic        exp_to;
    int          exp_done_c;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        to;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    instr_valid = 1'b0; dram_we = 1'b0; wd_sel = 2'b00; sl_type = 4'd0;
    alu_result = '0; rd2 = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  initial begin
    vec_t v;
    exp_t e;
    bit   done;

    // valid we wdsel sl addr rd2 rdata gnt rv | access mis addr wdata wstrb data to done_c
    vecs.push_back('{1, 0, 2'b01, 4'd3, 32'h100, 0, 32'hDEADBEEF, 0, 2,
                     1, 0, 32'h100, 0, 4'b0000, 32'hDEADBEEF, 0, 3});
    vecs.push_back('{1, 0, 2'b01, 4'd1, 32'h103, 0, 32'h80FF0000, 0, 0,
                     1, 0, 32'h100, 0, 4'b0000, 32'hFFFFFF80, 0, 1});
    vecs.push_back('{1, 0, 2'b01, 4'd4, 32'h103, 0, 32'h80FF0000, 0, 0,
                     1, 0, 32'h100, 0, 4'b0000, 32'h00000080, 0, 1});
    vecs.push_back('{1, 0, 2'b01, 4'd2, 32'h102, 0, 32'h80FF0000, 1, 1,
                     1, 0, 32'h100, 0, 4'b0000, 32'hFFFF80FF, 0, 2});
    vecs.push_back('{1, 0, 2'b01, 4'd5, 32'h100, 0, 32'h1234F00D, 0, 1,
                     1, 0, 32'h100, 0, 4'b0000, 32'h0000F00D, 0, 2});
    vecs.push_back('{1, 1, 2'b00, 4'd7, 32'h202, 32'h1234ABCD, 0, 0, NEVER,
                     1, 0, 32'h200, 32'hABCDABCD, 4'b1100, 0, 0, 1});
    vecs.push_back('{1, 1, 2'b00, 4'd6, 32'h201, 32'h1234ABCD, 0, 2, NEVER,
                     1, 0, 32'h200, 32'hCDCDCDCD, 4'b0010, 0, 0, 3});
    vecs.push_back('{1, 1, 2'b00, 4'd8, 32'h204, 32'hCAFEF00D, 0, 0, NEVER,
                     1, 0, 32'h204, 32'hCAFEF00D, 4'b1111, 0, 0, 1});
    vecs.push_back('{1, 1, 2'b00, 4'd8, 32'h102, 32'h11111111, 0, 0, NEVER,
                     1, 1, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 0, 2'b01, 4'd2, 32'h101, 0, 0, 0, 0,
                     1, 1, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 0, 2'b00, 4'd3, 32'h100, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 1, 2'b01, 4'd8, 32'h100, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 0, 2'b01, 4'd3, 32'h300, 0, 32'h77777777, NEVER, NEVER,
                     1, 0, 32'h300, 0, 4'b0000, 0, 1, 4});
    vecs.push_back('{1, 0, 2'b01, 4'd3, 32'h300, 0, 32'h77777777, 0, NEVER,
                     1, 0, 32'h300, 0, 4'b0000, 0, 1, 4});
    vecs.push_back('{1, 0, 2'b01, 4'd3, 32'h300, 0, 32'h55AA55AA, 0, 3,
                     1, 0, 32'h300, 0, 4'b0000, 32'h55AA55AA, 0, 4});
    vecs.push_back('{1, 1, 2'b00, 4'd8, 32'h308, 32'h0BADF00D, 0, 3, NEVER,
                     1, 0, 32'h308, 32'h0BADF00D, 4'b1111, 0, 0, 4});

    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_req", {31'd0, mem_req}, 0);
    chk("reset_addr", mem_addr, 0);
    chk("reset_wdata", mem_wdata, 0);
    chk("reset_wstrb_we", {27'd0, mem_wstrb, mem_we}, 0);
    chk("reset_done_to", {30'd0, mem_done, timeout}, 0);
    chk("reset_load", load_data, 0);
    chk("reset_stall", {31'd0, stall}, 0);

    // Bus responses while idle must be ignored.
    step();
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
    step();
    @(negedge clk);
    chk("idle_rsp_done", {31'd0, mem_done}, 0);
    chk("idle_rsp_load", load_data, 0);
    chk("idle_rsp_req", {31'd0, mem_req}, 0);
    clear_inputs();

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      step();
      instr_valid = v.valid; dram_we = v.we; wd_sel = v.wd_sel; sl_type = v.sl;
      alu_result = v.addr; rd2 = v.rd2; mem_rdata = v.rdata;
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_misalign", i), {31'd0, misalign}, {31'd0, v.exp_mis});
      chk($sformatf("v%0d_stall_detect", i), {31'd0, stall},
          {31'd0, v.exp_access & ~v.exp_mis});
      if (!v.exp_access || v.exp_mis) begin
        step();
        @(negedge clk);
        chk($sformatf("v%0d_no_req", i), {31'd0, mem_req}, 0);
      end else begin
        sb.push_back('{v.exp_data, v.exp_to});
        step();
        done = 1'b0;
        for (int c = 0; c < 12 && !done; c++) begin
          mem_gnt    = (c == v.gnt_at);
          mem_rvalid = (c == v.rv_at);
          @(negedge clk);
          if (c == 0) begin
            chk($sformatf("v%0d_addr", i), mem_addr, v.exp_addr);
            chk($sformatf("v%0d_wstrb", i), {28'd0, mem_wstrb}, {28'd0, v.exp_wstrb});
            chk($sformatf("v%0d_we", i), {31'd0, mem_we}, {31'd0, v.we});
            if (v.we) chk($sformatf("v%0d_wdata", i), mem_wdata, v.exp_wdata);
          end
          if (mem_done) begin
            done = 1'b1;
            chk($sformatf("v%0d_latency", i), c, v.exp_done_c);
            chk($sformatf("v%0d_done_stall", i), {31'd0, stall}, 0);
            chk($sformatf("v%0d_done_req", i), {31'd0, mem_req}, 0);
            if (sb.size() == 0) begin
              n_cmp++; n_bad++;
              $display("FAIL v%0d_scoreboard: got unexpected done, expected none", i);
            end else begin
              e = sb.pop_front();
              chk($sformatf("v%0d_load_data", i), load_data, e.data);
              chk($sformatf("v%0d_timeout", i), {31'd0, timeout}, {31'd0, e.to});
            end
          end else begin
            chk($sformatf("v%0d_c%0d_req", i, c), {31'd0, mem_req},
                {31'd0, (c <= v.gnt_at) && (c < TO)});
            chk($sformatf("v%0d_c%0d_stall", i, c), {31'd0, stall}, 1);
            step();
          end
        end
        if (!done) begin
          n_cmp++; n_bad++;
          $display("FAIL v%0d_done_wait: got no mem_done_o in 12 cycles, expected %0d",
                   i, v.exp_done_c);
          sb.delete();
        end
      end
      step();
      clear_inputs();
      @(negedge clk);
      chk($sformatf("v%0d_idle_done", i), {31'd0, mem_done}, 0);
      chk($sformatf("v%0d_idle_stall", i), {31'd0, stall}, 0);
    end

    // Reset while waiting for read data; the late rvalid must not complete anything.
    step();
    instr_valid = 1'b1; wd_sel = 2'b01; sl_type = 4'd3; alu_result = 32'h400;
    step();
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    @(negedge clk);
    chk("rst_mid_stall_wait", {31'd0, stall}, 1);
    chk("rst_mid_req_wait", {31'd0, mem_req}, 0);
    rst = 1'b1; instr_valid = 1'b0;
    step();
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    @(negedge clk);
    chk("rst_mid_stall", {31'd0, stall}, 0);
    chk("rst_mid_addr", mem_addr, 0);
    chk("rst_mid_done", {31'd0, mem_done}, 0);
    step();
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("rst_late_done", {31'd0, mem_done}, 0);
    chk("rst_late_load", load_data, 0);
    chk("rst_late_req", {31'd0, mem_req}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
